// File: rtl/logicnets_layer_skid_if.sv
// Valid/ready stream carrying one packed LogicNets layer vector.
interface logicnets_layer_skid_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/logicnets_layer_skid.sv
// Registered two-entry skid stage between LogicNets layers, with a wrapping
// delivered-beat counter for throughput profiling.
module logicnets_layer_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  logicnets_layer_skid_if.slave  s,
  logicnets_layer_skid_if.master m,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       beat_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s_ready_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic [CNT_W-1:0] beat_q;
  logic             m_valid_w;
  logic             s_fire, m_fire;
  logic             load_main, load_skid, main_from_skid;

  assign s_fire = s.valid & s_ready_q;
  assign m_fire = m_valid_w & m.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      // Registered look-ahead keeps m_ready off the upstream ready path.
      s_ready_q <= (state_d != FULL);
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (s_fire) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (s_fire && m_fire) begin
          load_main = 1'b1;
        end else if (s_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (m_fire) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (m_fire) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    m_valid_w = (state_q != EMPTY);
    occupancy = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
      beat_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : s.data;
      if (load_skid) skid_q <= s.data;
      if (m_fire)    beat_q <= beat_q + 1'b1;
    end
  end

  assign s.ready    = s_ready_q;
  assign m.valid    = m_valid_w;
  assign m.data     = main_q;
  assign beat_count = beat_q;

endmodule
